// File: rtl/register_file_pkg.sv
// Shared sizing for the architectural register file and its read ports.
// Widths derive from the register count and the ROB depth.
package register_file_pkg;

    localparam int REG_NUM         = 32;
    localparam int REG_INDEX_WIDTH = 5;
    localparam int ROB_SIZE        = 16;
    localparam int ROB_INDEX_WIDTH = 4;
    localparam int DATA_WIDTH      = 32;

    typedef logic [DATA_WIDTH-1:0]      data_t;
    typedef logic [ROB_INDEX_WIDTH-1:0] rob_index_t;
    typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;

endpackage

// File: rtl/register_file_reg_read_port.sv
// One decoder source read: x0 forcing, same-cycle commit bypass, then the
// stored value/busy/tag lookup.
module reg_read_port
    import register_file_pkg::*;
#(
    parameter int REG_NUM         = register_file_pkg::REG_NUM,
    parameter int REG_INDEX_WIDTH = register_file_pkg::REG_INDEX_WIDTH,
    parameter int ROB_INDEX_WIDTH = register_file_pkg::ROB_INDEX_WIDTH,
    parameter int DATA_WIDTH      = register_file_pkg::DATA_WIDTH
) (
    input  logic [REG_INDEX_WIDTH-1:0] rs,
    input  logic [REG_NUM-1:0]         busy,
    input  logic [ROB_INDEX_WIDTH-1:0] tags [REG_NUM],
    input  logic [DATA_WIDTH-1:0]      regs [REG_NUM],
    input  logic                       commit,
    input  logic [REG_INDEX_WIDTH-1:0] commit_rd,
    input  logic [ROB_INDEX_WIDTH-1:0] commit_tag,
    input  logic [DATA_WIDTH-1:0]      commit_val,
    output logic                       rs_busy,
    output logic [DATA_WIDTH-1:0]      rs_val,
    output logic [ROB_INDEX_WIDTH-1:0] rs_rob_index
);

    always_comb begin
        rs_busy      = busy[rs];
        rs_val       = regs[rs];
        rs_rob_index = tags[rs];
        if (rs == '0) begin
            rs_busy      = 1'b0;
            rs_val       = '0;
            rs_rob_index = '0;
        end else if (busy[rs] && commit && (commit_rd == rs) && (commit_tag == tags[rs])) begin
            // The producer retires this cycle, so hand its result over directly.
            rs_busy = 1'b0;
            rs_val  = commit_val;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags: commits from the
// ROB write values, issue renames mark the producing ROB entry, flush unbusies.
module register_file
    import register_file_pkg::*;
#(
    parameter int REG_NUM         = register_file_pkg::REG_NUM,
    parameter int REG_INDEX_WIDTH = register_file_pkg::REG_INDEX_WIDTH,
    parameter int ROB_INDEX_WIDTH = register_file_pkg::ROB_INDEX_WIDTH,
    parameter int DATA_WIDTH      = register_file_pkg::DATA_WIDTH
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clr_in,
    input  logic                       rob_to_reg_commit,
    input  logic [ROB_INDEX_WIDTH-1:0] rob_to_reg_rob_index,
    input  logic [REG_INDEX_WIDTH-1:0] rob_to_reg_index,
    input  logic [DATA_WIDTH-1:0]      rob_to_reg_val,
    input  logic                       dc_to_reg_rename,
    input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rd,
    input  logic [ROB_INDEX_WIDTH-1:0] dc_to_reg_rename_index,
    input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rs1,
    input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rs2,
    output logic                       reg_to_dc_rs1_busy,
    output logic [DATA_WIDTH-1:0]      reg_to_dc_rs1_val,
    output logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs1_rob_index,
    output logic                       reg_to_dc_rs2_busy,
    output logic [DATA_WIDTH-1:0]      reg_to_dc_rs2_val,
    output logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs2_rob_index
);

    logic [DATA_WIDTH-1:0]      regs [REG_NUM];
    logic [ROB_INDEX_WIDTH-1:0] tags [REG_NUM];
    logic [REG_NUM-1:0]         busy;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = rob_to_reg_commit && (rob_to_reg_index != '0);
    assign rename_ok = dc_to_reg_rename && (dc_to_reg_rd != '0) && !clr_in;

    // Later assignments win: a flush or a same-cycle rename overrides the
    // busy clear from a commit to the same register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_ok) begin
                regs[rob_to_reg_index] <= rob_to_reg_val;
                if (busy[rob_to_reg_index] && (tags[rob_to_reg_index] == rob_to_reg_rob_index))
                    busy[rob_to_reg_index] <= 1'b0;
            end
            if (clr_in) begin
                busy <= '0;
            end else if (rename_ok) begin
                busy[dc_to_reg_rd] <= 1'b1;
                tags[dc_to_reg_rd] <= dc_to_reg_rename_index;
            end
        end
    end

    reg_read_port #(
        .REG_NUM(REG_NUM), .REG_INDEX_WIDTH(REG_INDEX_WIDTH),
        .ROB_INDEX_WIDTH(ROB_INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_rs1 (
        .rs           (dc_to_reg_rs1),
        .busy         (busy),
        .tags         (tags),
        .regs         (regs),
        .commit       (rob_to_reg_commit),
        .commit_rd    (rob_to_reg_index),
        .commit_tag   (rob_to_reg_rob_index),
        .commit_val   (rob_to_reg_val),
        .rs_busy      (reg_to_dc_rs1_busy),
        .rs_val       (reg_to_dc_rs1_val),
        .rs_rob_index (reg_to_dc_rs1_rob_index)
    );

    reg_read_port #(
        .REG_NUM(REG_NUM), .REG_INDEX_WIDTH(REG_INDEX_WIDTH),
        .ROB_INDEX_WIDTH(ROB_INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_rs2 (
        .rs           (dc_to_reg_rs2),
        .busy         (busy),
        .tags         (tags),
        .regs         (regs),
        .commit       (rob_to_reg_commit),
        .commit_rd    (rob_to_reg_index),
        .commit_tag   (rob_to_reg_rob_index),
        .commit_val   (rob_to_reg_val),
        .rs_busy      (reg_to_dc_rs2_busy),
        .rs_val       (reg_to_dc_rs2_val),
        .rs_rob_index (reg_to_dc_rs2_rob_index)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: each record drives one cycle of
// inputs and states the combinational reads expected before that cycle's edge.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        rob_to_reg_commit;
    logic [3:0]  rob_to_reg_rob_index;
    logic [4:0]  rob_to_reg_index;
    logic [31:0] rob_to_reg_val;
    logic        dc_to_reg_rename;
    logic [4:0]  dc_to_reg_rd;
    logic [3:0]  dc_to_reg_rename_index;
    logic [4:0]  dc_to_reg_rs1, dc_to_reg_rs2;
    logic        reg_to_dc_rs1_busy, reg_to_dc_rs2_busy;
    logic [31:0] reg_to_dc_rs1_val, reg_to_dc_rs2_val;
    logic [3:0]  reg_to_dc_rs1_rob_index, reg_to_dc_rs2_rob_index;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    register_file dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        .clr_in                  (clr_in),
        .rob_to_reg_commit       (rob_to_reg_commit),
        .rob_to_reg_rob_index    (rob_to_reg_rob_index),
        .rob_to_reg_index        (rob_to_reg_index),
        .rob_to_reg_val          (rob_to_reg_val),
        .dc_to_reg_rename        (dc_to_reg_rename),
        .dc_to_reg_rd            (dc_to_reg_rd),
        .dc_to_reg_rename_index  (dc_to_reg_rename_index),
        .dc_to_reg_rs1           (dc_to_reg_rs1),
        .dc_to_reg_rs2           (dc_to_reg_rs2),
        .reg_to_dc_rs1_busy      (reg_to_dc_rs1_busy),
        .reg_to_dc_rs1_val       (reg_to_dc_rs1_val),
        .reg_to_dc_rs1_rob_index (reg_to_dc_rs1_rob_index),
        .reg_to_dc_rs2_busy      (reg_to_dc_rs2_busy),
        .reg_to_dc_rs2_val       (reg_to_dc_rs2_val),
        .reg_to_dc_rs2_rob_index (reg_to_dc_rs2_rob_index)
    );

    typedef struct {
        string       name;
        logic        rst, rdy, clr;
        logic        cm;
        logic [3:0]  cidx;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic        ren;
        logic [4:0]  rd;
        logic [3:0]  ridx;
        logic [4:0]  rs1, rs2;
        logic        b1;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic        b2;
        logic [31:0] v2;
        logic [3:0]  t2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst, logic rdy, logic clr,
                                logic cm, logic [3:0] cidx, logic [4:0] crd, logic [31:0] cval,
                                logic ren, logic [4:0] rd, logic [3:0] ridx,
                                logic [4:0] rs1, logic [4:0] rs2,
                                logic b1, logic [31:0] v1, logic [3:0] t1,
                                logic b2, logic [31:0] v2, logic [3:0] t2);
        vec_t v;
        v.name = name; v.rst = rst; v.rdy = rdy; v.clr = clr;
        v.cm = cm; v.cidx = cidx; v.crd = crd; v.cval = cval;
        v.ren = ren; v.rd = rd; v.ridx = ridx; v.rs1 = rs1; v.rs2 = rs2;
        v.b1 = b1; v.v1 = v1; v.t1 = t1; v.b2 = b2; v.v2 = v2; v.t2 = t2;
        return v;
    endfunction

    task automatic drive(vec_t v);
        rst_in = v.rst; rdy_in = v.rdy; clr_in = v.clr;
        rob_to_reg_commit = v.cm; rob_to_reg_rob_index = v.cidx;
        rob_to_reg_index = v.crd; rob_to_reg_val = v.cval;
        dc_to_reg_rename = v.ren; dc_to_reg_rd = v.rd; dc_to_reg_rename_index = v.ridx;
        dc_to_reg_rs1 = v.rs1; dc_to_reg_rs2 = v.rs2;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_vec(vec_t v);
        check({v.name, ".rs1_busy"}, 32'(reg_to_dc_rs1_busy),      32'(v.b1));
        check({v.name, ".rs1_val"},  reg_to_dc_rs1_val,            v.v1);
        check({v.name, ".rs1_tag"},  32'(reg_to_dc_rs1_rob_index), 32'(v.t1));
        check({v.name, ".rs2_busy"}, 32'(reg_to_dc_rs2_busy),      32'(v.b2));
        check({v.name, ".rs2_val"},  reg_to_dc_rs2_val,            v.v2);
        check({v.name, ".rs2_tag"},  32'(reg_to_dc_rs2_rob_index), 32'(v.t2));
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          name         rst rdy clr cm cidx crd cval          ren rd ridx rs1 rs2  b1 v1            t1  b2 v2     t2
        vecs.push_back(mk("after_reset", 0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  5,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("ren_x5",      0, 1, 0, 0, 0, 0, 0,            1, 5, 3,  5,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("x5_busy",     0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  5,  0,  1, 0,            3,  0, 0,     0));
        vecs.push_back(mk("x5_bypass",   0, 1, 0, 1, 3, 5, 32'hDEADBEEF, 0, 0, 0,  5,  5,  0, 32'hDEADBEEF, 3,  0, 32'hDEADBEEF, 3));
        vecs.push_back(mk("x5_stored",   0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  5,  0,  0, 32'hDEADBEEF, 3,  0, 0,     0));
        vecs.push_back(mk("ren_x7_t2",   0, 1, 0, 0, 0, 0, 0,            1, 7, 2,  7,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("ren_x7_t6",   0, 1, 0, 0, 0, 0, 0,            1, 7, 6,  7,  0,  1, 0,            2,  0, 0,     0));
        vecs.push_back(mk("x7_old_cm",   0, 1, 0, 1, 2, 7, 32'h11,       0, 0, 0,  7,  0,  1, 0,            6,  0, 0,     0));
        vecs.push_back(mk("x7_young",    0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  7,  0,  1, 32'h11,       6,  0, 0,     0));
        vecs.push_back(mk("ren_x9_t4",   0, 1, 0, 0, 0, 0, 0,            1, 9, 4,  9,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("x9_cm_ren",   0, 1, 0, 1, 4, 9, 32'h22,       1, 9, 8,  9,  0,  0, 32'h22,       4,  0, 0,     0));
        vecs.push_back(mk("x9_after",    0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  9,  0,  1, 32'h22,       8,  0, 0,     0));
        vecs.push_back(mk("ren_x1",      0, 1, 0, 0, 0, 0, 0,            1, 1, 10, 1,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("ren_x2",      0, 1, 0, 0, 0, 0, 0,            1, 2, 11, 1,  2,  1, 0,            10, 0, 0,     0));
        vecs.push_back(mk("flush",       0, 1, 1, 1, 10, 1, 32'h33,      1, 3, 1,  1,  2,  0, 32'h33,       10, 1, 0,     11));
        vecs.push_back(mk("post_flush",  0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  1,  2,  0, 32'h33,       10, 0, 0,     11));
        vecs.push_back(mk("flush_x3_x7", 0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  3,  7,  0, 0,            0,  0, 32'h11, 6));
        vecs.push_back(mk("x0_writes",   0, 1, 0, 1, 0, 0, 32'h44,       1, 0, 5,  0,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("x0_after",    0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  0,  1,  0, 0,            0,  0, 32'h33, 10));
        vecs.push_back(mk("frozen_x4",   0, 0, 0, 1, 0, 4, 32'h55,       1, 4, 7,  4,  0,  0, 0,            0,  0, 0,     0));
        vecs.push_back(mk("x4_unchanged",0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  4,  9,  0, 0,            0,  0, 32'h22, 8));
        vecs.push_back(mk("mid_reset",   1, 1, 0, 0, 0, 0, 0,            0, 0, 0,  9,  5,  0, 32'h22,       8,  0, 32'hDEADBEEF, 3));
        vecs.push_back(mk("reset_clear", 0, 1, 0, 0, 0, 0, 0,            0, 0, 0,  9,  5,  0, 0,            0,  0, 0,     0));

        drive(idle);
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check_vec(vecs[i]);
            @(negedge clk_in);
        end

        // Frozen cycle with flush and commit asserted must not disturb a busy register.
        drive(idle);
        dc_to_reg_rename = 1'b1; dc_to_reg_rd = 5'd12; dc_to_reg_rename_index = 4'd9;
        @(negedge clk_in);
        drive(idle);
        rdy_in = 1'b0; clr_in = 1'b1;
        rob_to_reg_commit = 1'b1; rob_to_reg_index = 5'd13; rob_to_reg_val = 32'h66;
        @(negedge clk_in);
        drive(idle);
        dc_to_reg_rs1 = 5'd12; dc_to_reg_rs2 = 5'd13;
        #2;
        check("hold.x12_busy", 32'(reg_to_dc_rs1_busy), 32'd1);
        check("hold.x12_tag",  32'(reg_to_dc_rs1_rob_index), 32'd9);
        check("hold.x13_val",  reg_to_dc_rs2_val, 32'd0);

        // Flush in the same cycle as a rename of the same register leaves it idle.
        @(negedge clk_in);
        drive(idle);
        clr_in = 1'b1; dc_to_reg_rename = 1'b1; dc_to_reg_rd = 5'd12; dc_to_reg_rename_index = 4'd2;
        @(negedge clk_in);
        drive(idle);
        dc_to_reg_rs1 = 5'd12;
        #2;
        check("flush_ren.x12_busy", 32'(reg_to_dc_rs1_busy), 32'd0);
        check("flush_ren.x12_tag",  32'(reg_to_dc_rs1_rob_index), 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags; the receiving end of the ROB commit interface (commit valid, ROB index, rd, value) and of the ROB flush (`clr_in`).
- Records which ROB entry will produce each register, as renamed at issue.
- Gives the decoder each source's committed value, or the ROB tag it must wait on, with same-cycle commit bypass.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- REG_INDEX_WIDTH, 5, log2(REG_NUM)
- ROB_INDEX_WIDTH, 4, ROB tag width (ROB_SIZE = 16)
- DATA_WIDTH, 32, register data width

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low = freeze all state
- clr_in  input  1  flush from ROB (mispredict)
- rob_to_reg_commit  input  1  commit valid this cycle
- rob_to_reg_rob_index  input  ROB_INDEX_WIDTH  ROB tag of committing entry
- rob_to_reg_index  input  REG_INDEX_WIDTH  destination register of commit
- rob_to_reg_val  input  DATA_WIDTH  commit value
- dc_to_reg_rename  input  1  issue renames a destination this cycle
- dc_to_reg_rd  input  REG_INDEX_WIDTH  destination being renamed
- dc_to_reg_rename_index  input  ROB_INDEX_WIDTH  new ROB tag for rd
- dc_to_reg_rs1  input  REG_INDEX_WIDTH  source 1 index
- dc_to_reg_rs2  input  REG_INDEX_WIDTH  source 2 index
- reg_to_dc_rs1_busy  output  1  rs1 awaits a ROB result
- reg_to_dc_rs1_val  output  DATA_WIDTH  rs1 value (valid when not busy)
- reg_to_dc_rs1_rob_index  output  ROB_INDEX_WIDTH  rs1 producer tag (valid when busy)
- reg_to_dc_rs2_busy / reg_to_dc_rs2_val / reg_to_dc_rs2_rob_index  output  1 / DATA_WIDTH / ROB_INDEX_WIDTH  same for rs2

Behaviour:
- State: `regs[REG_NUM]`, `busy[REG_NUM]`, `tag[REG_NUM]`. All updates on posedge `clk_in`.
- Reset (`rst_in`=1): all regs, busy and tag are 0. Read outputs are combinational, so after reset every read returns busy=0, val=0, rob_index=0.
- `rdy_in`=0 and not reset: no state change; all inputs ignored. Reads still reflect current state.
- Commit (`rob_to_reg_commit`=1, rd≠0):
  - `regs[rd]` <= val, always.
  - busy[rd] <= 0 only if busy[rd]=1 and tag[rd]==`rob_to_reg_rob_index`; otherwise a younger rename owns rd and busy stays set.
- Rename (`dc_to_reg_rename`=1, rd≠0, `clr_in`=0): busy[rd] <= 1, tag[rd] <= `dc_to_reg_rename_index`.
- Commit and rename to the same rd in one cycle: value written, rename's busy/tag win.
- Flush (`clr_in`=1):
  - Commit write still performed, because the mispredicted branch commits in the same cycle as the flush.
  - All busy bits cleared.
  - Rename ignored.
  - Tags need not be cleared.
- x0: writes ignored, never busy, reads always busy=0, val=0.
- Read path (per port, combinational), evaluated in priority order:
  1. rs=0: busy=0, val=0.
  2. busy[rs]=1 and commit valid this cycle with rd==rs and commit tag==tag[rs]: busy=0, val=`rob_to_reg_val` (bypass).
  3. Otherwise: busy=busy[rs], val=regs[rs], rob_index=tag[rs].
  - A rename in the same cycle does not affect the reads; the decoder reads sources before renaming its own rd.
- Latency: commit is visible via bypass in the same cycle and in stored state the next cycle; a rename is visible the next cycle.

Decomposition:
- `def.v` holds `DATA_TYPE`, `ROB_INDEX_TYPE`, `REG_INDEX_TYPE`, `TRUE`/`FALSE`, ROB_SIZE and REG_NUM macros; this block uses them.
- One natural sub-module, `reg_read_port`: the combinational x0/bypass/lookup mux, instantiated for rs1 and rs2.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> busy=0, val=0 on both ports.
- Rename x5 tag 3; next cycle read x5 -> busy=1, rob_index=3. Commit x5 tag 3 val 0xDEADBEEF in the same cycle as the read -> busy=0, val=0xDEADBEEF via bypass. Following cycle -> stored val 0xDEADBEEF, busy=0.
- Rename x7 tag 2, then rename x7 tag 6, then commit x7 tag 2 val 0x11 -> regs[7]=0x11, busy=1, rob_index=6.
- In one cycle commit x9 tag 4 val 0x22 (x9 busy with tag 4) and rename x9 tag 8 -> next cycle busy=1, tag=8, regs[9]=0x22.
- x1, x2 busy; in one cycle assert `clr_in` with commit x1 val 0x33 and rename x3 tag 1 -> next cycle all busy=0, x1=0x33, x3 not busy.
- Commit x0 val 0x44 and rename x0 -> x0 reads 0, not busy. With `rdy_in`=0, rename x4 -> x4 unchanged.
